// File: rtl/decode_control_stage.sv
// Decode/control stage: registered RV32I(+M) control bundle with valid/ready
// handshake and a fixed busy reservation after each divide handoff.
module decode_control_stage #(
    parameter int ENABLE_M   = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] INSTRUCTION,
    input  logic        FLUSH,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [4:0]  ALUOP,
    output logic [2:0]  MUXIMMTYPE_SELECT,
    output logic        MUXPC_SELECT,
    output logic        MUXIMM_SELECT,
    output logic        MUXJAL_SELECT,
    output logic        MUXDATAMEM_SELECT,
    output logic        WRITE_ENABLE,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BRANCH,
    output logic        JUMP,
    output logic [2:0]  FUNCT3_OUT,
    output logic        ILLEGAL,
    output logic        BUSY
);

    localparam logic [4:0] ALU_PASS   = 5'b00000;
    localparam logic [4:0] ALU_ADD    = 5'b00001;
    localparam logic [4:0] ALU_SUB    = 5'b00010;
    localparam logic [4:0] ALU_SLL    = 5'b00011;
    localparam logic [4:0] ALU_SLT    = 5'b00100;
    localparam logic [4:0] ALU_SLTU   = 5'b00101;
    localparam logic [4:0] ALU_XOR    = 5'b00110;
    localparam logic [4:0] ALU_SRL    = 5'b00111;
    localparam logic [4:0] ALU_SRA    = 5'b01000;
    localparam logic [4:0] ALU_OR     = 5'b01001;
    localparam logic [4:0] ALU_AND    = 5'b01010;
    localparam logic [4:0] ALU_MUL    = 5'b01011;
    localparam logic [4:0] ALU_MULH   = 5'b01100;
    localparam logic [4:0] ALU_MULHSU = 5'b01101;
    localparam logic [4:0] ALU_MULHU  = 5'b01110;
    localparam logic [4:0] ALU_DIV    = 5'b01111;
    localparam logic [4:0] ALU_DIVU   = 5'b10000;
    localparam logic [4:0] ALU_REM    = 5'b10001;
    localparam logic [4:0] ALU_REMU   = 5'b10010;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [7:0] DIV_LOAD = 8'(DIV_CYCLES - 1);
    localparam bit         MEXT     = (ENABLE_M != 0);

    typedef enum logic {RUN, WAIT_DIV} state_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_bits;

    assign opc = INSTRUCTION[6:0];
    assign f3  = INSTRUCTION[14:12];
    assign f7  = INSTRUCTION[31:25];
    assign unused_bits = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

    // ctl packs {PC, IMM, JAL, DATAMEM, WE, MR, MW, BR, J}
    logic [4:0] dec_alu;
    logic [2:0] dec_imm;
    logic [8:0] dec_ctl;
    logic       dec_ill;
    logic       dec_div;
    logic [4:0] raw_alu;
    logic [2:0] raw_imm;
    logic [8:0] raw_ctl;
    logic       raw_ill;

    always_comb begin
        raw_alu = ALU_PASS;
        raw_imm = 3'b111;
        raw_ctl = 9'b0;
        raw_ill = 1'b0;
        case (opc)
            OP_R: begin
                raw_imm = 3'b111;
                raw_ctl = 9'b0000_10000;
                if (f7 == 7'b0000001) begin
                    if (!MEXT) begin
                        raw_ill = 1'b1;
                    end else begin
                        case (f3)
                            3'b000:  raw_alu = ALU_MUL;
                            3'b001:  raw_alu = ALU_MULH;
                            3'b010:  raw_alu = ALU_MULHSU;
                            3'b011:  raw_alu = ALU_MULHU;
                            3'b100:  raw_alu = ALU_DIV;
                            3'b101:  raw_alu = ALU_DIVU;
                            3'b110:  raw_alu = ALU_REM;
                            default: raw_alu = ALU_REMU;
                        endcase
                    end
                end else if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000:  raw_alu = ALU_ADD;
                        3'b001:  raw_alu = ALU_SLL;
                        3'b010:  raw_alu = ALU_SLT;
                        3'b011:  raw_alu = ALU_SLTU;
                        3'b100:  raw_alu = ALU_XOR;
                        3'b101:  raw_alu = ALU_SRL;
                        3'b110:  raw_alu = ALU_OR;
                        default: raw_alu = ALU_AND;
                    endcase
                end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
                    raw_alu = ALU_SUB;
                end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
                    raw_alu = ALU_SRA;
                end else begin
                    raw_ill = 1'b1;
                end
            end
            OP_IMM: begin
                raw_imm = 3'b000;
                raw_ctl = 9'b0100_10000;
                case (f3)
                    3'b000: raw_alu = ALU_ADD;
                    3'b010: raw_alu = ALU_SLT;
                    3'b011: raw_alu = ALU_SLTU;
                    3'b100: raw_alu = ALU_XOR;
                    3'b110: raw_alu = ALU_OR;
                    3'b111: raw_alu = ALU_AND;
                    3'b001: begin
                        raw_alu = ALU_SLL;
                        raw_ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        if (f7 == 7'b0000000) begin
                            raw_alu = ALU_SRL;
                        end else if (f7 == 7'b0100000) begin
                            raw_alu = ALU_SRA;
                        end else begin
                            raw_ill = 1'b1;
                        end
                    end
                endcase
            end
            OP_LOAD: begin
                raw_alu = ALU_ADD;
                raw_imm = 3'b000;
                raw_ctl = 9'b0101_11000;
            end
            OP_STORE: begin
                raw_alu = ALU_ADD;
                raw_imm = 3'b001;
                raw_ctl = 9'b0100_00100;
            end
            OP_JALR: begin
                raw_alu = ALU_ADD;
                raw_imm = 3'b000;
                raw_ctl = 9'b0110_10001;
            end
            OP_AUIPC: begin
                raw_alu = ALU_ADD;
                raw_imm = 3'b011;
                raw_ctl = 9'b1100_10000;
            end
            OP_LUI: begin
                raw_alu = ALU_PASS;
                raw_imm = 3'b011;
                raw_ctl = 9'b0100_10000;
            end
            OP_BR: begin
                raw_alu = ALU_SUB;
                raw_imm = 3'b010;
                raw_ctl = 9'b1100_00010;
            end
            OP_JAL: begin
                raw_alu = ALU_ADD;
                raw_imm = 3'b100;
                raw_ctl = 9'b1110_10001;
            end
            default: raw_ill = 1'b1;
        endcase
    end

    // Illegal bundles carry a neutral control word so nothing downstream fires
    always_comb begin
        dec_ill = raw_ill;
        dec_alu = raw_ill ? ALU_PASS : raw_alu;
        dec_imm = raw_ill ? 3'b111 : raw_imm;
        dec_ctl = raw_ill ? 9'b0 : raw_ctl;
        dec_div = !raw_ill && (opc == OP_R) && (f7 == 7'b0000001) && f3[2];
    end

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       ov_q;
    logic       div_q;
    logic       ill_q;
    logic [4:0] alu_q;
    logic [2:0] imm_q;
    logic [8:0] ctl_q;
    logic [2:0] f3_q;
    logic       accept;
    logic       handoff;

    assign IN_READY = (!ov_q || OUT_READY) && (state_q == RUN) && !FLUSH;
    assign accept   = IN_VALID && IN_READY;
    assign handoff  = ov_q && OUT_READY;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            ov_q    <= 1'b0;
            div_q   <= 1'b0;
            ill_q   <= 1'b0;
            alu_q   <= ALU_PASS;
            imm_q   <= 3'b111;
            ctl_q   <= 9'b0;
            f3_q    <= 3'b000;
        end else if (FLUSH) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            ov_q    <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (handoff && div_q) begin
                        state_q <= WAIT_DIV;
                        cnt_q   <= DIV_LOAD;
                    end
                end
                default: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= RUN;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
            endcase
            if (accept) begin
                ov_q  <= 1'b1;
                div_q <= dec_div;
                ill_q <= dec_ill;
                alu_q <= dec_alu;
                imm_q <= dec_imm;
                ctl_q <= dec_ctl;
                f3_q  <= f3;
            end else if (handoff) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign OUT_VALID         = ov_q;
    assign ALUOP             = alu_q;
    assign MUXIMMTYPE_SELECT = imm_q;
    assign MUXPC_SELECT      = ctl_q[8];
    assign MUXIMM_SELECT     = ctl_q[7];
    assign MUXJAL_SELECT     = ctl_q[6];
    assign MUXDATAMEM_SELECT = ctl_q[5];
    assign WRITE_ENABLE      = ctl_q[4];
    assign MEM_READ          = ctl_q[3];
    assign MEM_WRITE         = ctl_q[2];
    assign BRANCH            = ctl_q[1];
    assign JUMP              = ctl_q[0];
    assign FUNCT3_OUT        = f3_q;
    assign ILLEGAL           = ill_q;
    assign BUSY              = (state_q == WAIT_DIV);

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: vector table plus
// handshake, divide-reservation, flush and reset sequences.
module tb_decode_control_stage;

    logic        CLK = 1'b0;
    logic        RESET, IN_VALID, OUT_READY, FLUSH;
    logic [31:0] INSTRUCTION;

    logic       a_ir, a_ov, a_pc, a_mi, a_jl, a_dm, a_we, a_mr, a_mw, a_br, a_j;
    logic       a_ill, a_busy;
    logic [4:0] a_alu;
    logic [2:0] a_imm, a_f3;
    logic       b_ir, b_ov, b_pc, b_mi, b_jl, b_dm, b_we, b_mr, b_mw, b_br, b_j;
    logic       b_ill, b_busy;
    logic [4:0] b_alu;
    logic [2:0] b_imm, b_f3;
    logic [8:0] a_ctl, b_ctl;

    assign a_ctl = {a_pc, a_mi, a_jl, a_dm, a_we, a_mr, a_mw, a_br, a_j};
    assign b_ctl = {b_pc, b_mi, b_jl, b_dm, b_we, b_mr, b_mw, b_br, b_j};

    always #5 CLK = ~CLK;

    decode_control_stage #(.ENABLE_M(1), .DIV_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(a_ir),
        .INSTRUCTION(INSTRUCTION), .FLUSH(FLUSH), .OUT_VALID(a_ov),
        .OUT_READY(OUT_READY), .ALUOP(a_alu), .MUXIMMTYPE_SELECT(a_imm),
        .MUXPC_SELECT(a_pc), .MUXIMM_SELECT(a_mi), .MUXJAL_SELECT(a_jl),
        .MUXDATAMEM_SELECT(a_dm), .WRITE_ENABLE(a_we), .MEM_READ(a_mr),
        .MEM_WRITE(a_mw), .BRANCH(a_br), .JUMP(a_j), .FUNCT3_OUT(a_f3),
        .ILLEGAL(a_ill), .BUSY(a_busy)
    );

    decode_control_stage #(.ENABLE_M(0), .DIV_CYCLES(4)) dut_nm (
        .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(b_ir),
        .INSTRUCTION(INSTRUCTION), .FLUSH(FLUSH), .OUT_VALID(b_ov),
        .OUT_READY(OUT_READY), .ALUOP(b_alu), .MUXIMMTYPE_SELECT(b_imm),
        .MUXPC_SELECT(b_pc), .MUXIMM_SELECT(b_mi), .MUXJAL_SELECT(b_jl),
        .MUXDATAMEM_SELECT(b_dm), .WRITE_ENABLE(b_we), .MEM_READ(b_mr),
        .MEM_WRITE(b_mw), .BRANCH(b_br), .JUMP(b_j), .FUNCT3_OUT(b_f3),
        .ILLEGAL(b_ill), .BUSY(b_busy)
    );

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  alu;
        logic [2:0]  imm;
        logic [8:0]  ctl;
        logic        ill;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h402081B3;
    localparam logic [31:0] I_MUL = 32'h022081B3;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
    localparam logic [31:0] I_BAD = 32'h0000007F;

    function automatic vec_t mk(input logic [31:0] i, input logic [4:0] a,
                                input logic [2:0] m, input logic [8:0] c,
                                input logic l);
        vec_t v;
        v.ins = i; v.alu = a; v.imm = m; v.ctl = c; v.ill = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b1; IN_VALID = 1'b0; FLUSH = 1'b0; OUT_READY = 1'b0;
        tick();
        RESET = 1'b0;
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ov"}, 32'(a_ov), 0);
        chk({tag, "_busy"}, 32'(a_busy), 0);
        chk({tag, "_ill"}, 32'(a_ill), 0);
        chk({tag, "_alu"}, 32'(a_alu), 0);
        chk({tag, "_imm"}, 32'(a_imm), 32'h7);
        chk({tag, "_ctl"}, 32'(a_ctl), 0);
        chk({tag, "_f3"}, 32'(a_f3), 0);
    endtask

    initial begin
        int n;
        logic [31:0] ins;
        RESET = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
        INSTRUCTION = 32'h0;

        vt.push_back(mk(I_ADD, 5'b00001, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0000A183, 5'b00001, 3'b000, 9'b0101_11000, 0));
        vt.push_back(mk(I_SUB, 5'b00010, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h002091B3, 5'b00011, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020A1B3, 5'b00100, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020B1B3, 5'b00101, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020C1B3, 5'b00110, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020D1B3, 5'b00111, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h4020D1B3, 5'b01000, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020E1B3, 5'b01001, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0020F1B3, 5'b01010, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(I_MUL, 5'b01011, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h022091B3, 5'b01100, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0220A1B3, 5'b01101, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h0220B1B3, 5'b01110, 3'b111, 9'b0000_10000, 0));
        vt.push_back(mk(32'h00508193, 5'b00001, 3'b000, 9'b0100_10000, 0));
        vt.push_back(mk(32'h00309193, 5'b00011, 3'b000, 9'b0100_10000, 0));
        vt.push_back(mk(32'h4030D193, 5'b01000, 3'b000, 9'b0100_10000, 0));
        vt.push_back(mk(32'h40309193, 5'b00000, 3'b111, 9'b0, 1));
        vt.push_back(mk(32'h0020A023, 5'b00001, 3'b001, 9'b0100_00100, 0));
        vt.push_back(mk(32'h00208063, 5'b00010, 3'b010, 9'b1100_00010, 0));
        vt.push_back(mk(32'h000081E7, 5'b00001, 3'b000, 9'b0110_10001, 0));
        vt.push_back(mk(32'h00001197, 5'b00001, 3'b011, 9'b1100_10000, 0));
        vt.push_back(mk(32'h000011B7, 5'b00000, 3'b011, 9'b0100_10000, 0));
        vt.push_back(mk(32'h000001EF, 5'b00001, 3'b100, 9'b1110_10001, 0));
        vt.push_back(mk(I_BAD, 5'b00000, 3'b111, 9'b0, 1));
        vt.push_back(mk(32'h042081B3, 5'b00000, 3'b111, 9'b0, 1));

        tick(); tick();
        chk_reset("rst");
        RESET = 1'b0;
        #1;
        chk("rst_in_ready", 32'(a_ir), 1);

        // back-to-back vectors, one bundle per cycle
        OUT_READY = 1'b1;
        for (int i = 0; i < vt.size(); i++) begin
            INSTRUCTION = vt[i].ins;
            IN_VALID = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(a_ir), 1);
            tick();
            ins = vt[i].ins;
            chk($sformatf("v%0d_ov", i), 32'(a_ov), 1);
            chk($sformatf("v%0d_alu", i), 32'(a_alu), 32'(vt[i].alu));
            chk($sformatf("v%0d_imm", i), 32'(a_imm), 32'(vt[i].imm));
            chk($sformatf("v%0d_ctl", i), 32'(a_ctl), 32'(vt[i].ctl));
            chk($sformatf("v%0d_ill", i), 32'(a_ill), 32'(vt[i].ill));
            chk($sformatf("v%0d_f3", i), 32'(a_f3), 32'(ins[14:12]));
        end
        IN_VALID = 1'b0;
        tick();
        chk("drain_ov", 32'(a_ov), 0);

        // stall: held bundle stable, new instruction refused
        do_reset();
        INSTRUCTION = I_SUB; IN_VALID = 1'b1; OUT_READY = 1'b0;
        tick();
        INSTRUCTION = I_ADD;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_ov", k), 32'(a_ov), 1);
            chk($sformatf("stall%0d_alu", k), 32'(a_alu), 32'h02);
            chk($sformatf("stall%0d_ir", k), 32'(a_ir), 0);
            if (k < 2) tick();
        end
        OUT_READY = 1'b1;
        #1;
        chk("stall_release_ir", 32'(a_ir), 1);
        tick();
        chk("stall_next_ov", 32'(a_ov), 1);
        chk("stall_next_alu", 32'(a_alu), 32'h01);
        IN_VALID = 1'b0;
        tick();
        chk("stall_drain_ov", 32'(a_ov), 0);

        // divide reservation
        do_reset();
        INSTRUCTION = I_DIV; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        chk("div_ov", 32'(a_ov), 1);
        chk("div_alu", 32'(a_alu), 32'h0F);
        chk("div_busy_pre", 32'(a_busy), 0);
        IN_VALID = 1'b0;
        tick();
        INSTRUCTION = I_ADD; IN_VALID = 1'b1;
        #1;
        n = 0;
        while (!a_ir && n < 20) begin
            chk($sformatf("div_w%0d_busy", n), 32'(a_busy), 1);
            chk($sformatf("div_w%0d_ov", n), 32'(a_ov), 0);
            n++;
            tick();
        end
        chk("div_wait_cycles", n, 4);
        chk("div_busy_post", 32'(a_busy), 0);
        tick();
        chk("div_after_ov", 32'(a_ov), 1);
        chk("div_after_alu", 32'(a_alu), 32'h01);
        INSTRUCTION = I_MUL;
        tick();
        chk("mul_alu", 32'(a_alu), 32'h0B);
        IN_VALID = 1'b0;
        tick();
        chk("mul_busy", 32'(a_busy), 0);
        chk("mul_ir", 32'(a_ir), 1);

        // M-extension disabled
        do_reset();
        INSTRUCTION = I_MUL; IN_VALID = 1'b1; OUT_READY = 1'b0;
        tick();
        chk("nm_mul_ov", 32'(b_ov), 1);
        chk("nm_mul_ill", 32'(b_ill), 1);
        chk("nm_mul_we", 32'(b_we), 0);
        chk("nm_mul_alu", 32'(b_alu), 0);
        chk("nm_mul_imm", 32'(b_imm), 32'h7);
        tick();
        chk("nm_hold_ov", 32'(b_ov), 1);
        OUT_READY = 1'b1; INSTRUCTION = I_BAD;
        tick();
        chk("nm_bad_ill", 32'(b_ill), 1);
        chk("nm_bad_ctl", 32'(b_ctl), 0);
        chk("nm_mul_busy", 32'(b_busy), 0);
        INSTRUCTION = I_DIV;
        tick();
        chk("nm_div_ill", 32'(b_ill), 1);
        IN_VALID = 1'b0;
        tick();
        chk("nm_div_busy", 32'(b_busy), 0);
        chk("nm_div_ir", 32'(b_ir), 1);

        // flush beats a divide handoff
        do_reset();
        INSTRUCTION = I_DIV; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        INSTRUCTION = I_ADD; FLUSH = 1'b1;
        #1;
        chk("flush_ir", 32'(a_ir), 0);
        tick();
        FLUSH = 1'b0; IN_VALID = 1'b0;
        #1;
        chk("flush_ov", 32'(a_ov), 0);
        chk("flush_busy", 32'(a_busy), 0);
        chk("flush_ir_after", 32'(a_ir), 1);
        tick();
        chk("flush_busy2", 32'(a_busy), 0);

        // reset in the middle of a reservation with a held bundle
        do_reset();
        INSTRUCTION = I_DIV; IN_VALID = 1'b1; OUT_READY = 1'b1;
        tick();
        INSTRUCTION = I_ADD;
        tick();
        chk("rw_busy3", 32'(a_busy), 1);
        chk("rw_held_alu", 32'(a_alu), 32'h01);
        OUT_READY = 1'b0; IN_VALID = 1'b0;
        tick();
        chk("rw_busy2", 32'(a_busy), 1);
        chk("rw_held_ov", 32'(a_ov), 1);
        RESET = 1'b1;
        tick();
        chk_reset("rw");
        RESET = 1'b0;
        #1;
        chk("rw_ir", 32'(a_ir), 1);
        tick();
        chk("rw_busy_after", 32'(a_busy), 0);
        chk("rw_ov_after", 32'(a_ov), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_control_stage.md
DECODE_CONTROL_STAGE -- requirements
Module: decode_control_stage

Interface
REQ-001 Parameters SHALL be:
- ENABLE_M, 1, M-extension decode enable.
- DIV_CYCLES, 32, busy cycles reserved after each DIV/DIVU/REM/REMU handoff; legal range 1..255.
REQ-002 Ports SHALL be:
- CLK  in  1  clock.
- RESET  in  1  reset.
- IN_VALID  in  1  INSTRUCTION valid.
- IN_READY  out  1  stage accepts INSTRUCTION.
- INSTRUCTION  in  32  fetched instruction.
- FLUSH  in  1  discard held decode.
- OUT_VALID  out  1  decoded bundle valid.
- OUT_READY  in  1  consumer accepts bundle.
- ALUOP  out  5  ALU operation.
- MUXIMMTYPE_SELECT  out  3  immediate format.
- MUXPC_SELECT, MUXIMM_SELECT, MUXJAL_SELECT, MUXDATAMEM_SELECT  out  1 each  datapath mux selects.
- WRITE_ENABLE, MEM_READ, MEM_WRITE, BRANCH, JUMP  out  1 each  stage enables.
- FUNCT3_OUT  out  3  INSTRUCTION[14:12] of the held instruction.
- ILLEGAL  out  1  held instruction undecodable.
- BUSY  out  1  multicycle reservation active.
REQ-003 One clock, CLK; RESET is synchronous and active-high.

Function
REQ-004 All outputs SHALL be registered; accepted instruction appears on outputs the cycle after the IN_VALID&&IN_READY edge (latency 1).
REQ-005 IN_READY SHALL equal (!OUT_VALID || OUT_READY) && state==RUN && !FLUSH.
REQ-006 OUT_VALID SHALL hold, with outputs stable, until OUT_READY; accept and handoff in the same cycle SHALL load the new bundle with no bubble.
REQ-007 ALUOP codes SHALL be: ADD 00001, SUB 00010, SLL 00011, SLT 00100, SLTU 00101, XOR 00110, SRL 00111, SRA 01000, OR 01001, AND 01010, MUL 01011, MULH 01100, MULHSU 01101, MULHU 01110, DIV 01111, DIVU 10000, REM 10001, REMU 10010, pass-B 00000.
REQ-008 Decode: R 0110011 on {funct7,funct3}; OP-IMM 0010011 on funct3, slli/srli/srai also on funct7; load 0000011, store 0100011, jalr 1100111, auipc 0010111, jal 1101111 use ADD; lui 0110111 uses pass-B; branch 1100011 uses SUB.
REQ-009 Mux/enable values SHALL be, as MUXPC/MUXIMM/MUXJAL/MUXDATAMEM/WE/MR/MW/BR/J: R 0000 10000; OP-IMM 0100 10000; load 0101 11000; store 0100 00100; jalr 0110 10001; auipc 1100 10000; lui 0100 10000; branch 1100 00010; jal 1110 10001.
REQ-010 MUXIMMTYPE_SELECT SHALL be 000 I-type (OP-IMM, load, jalr), 001 S, 010 B, 011 U (lui, auipc), 100 J, 111 R-type.
REQ-011 Unknown opcode, unlisted funct combination, or funct7=0000001 with ENABLE_M=0 SHALL set ILLEGAL=1, ALUOP=00000, all nine mux/enable bits 0, MUXIMMTYPE_SELECT 111; ILLEGAL bundle still follows the handshake.
REQ-012 FSM states SHALL be RUN and WAIT_DIV; RUN->WAIT_DIV when a DIV/DIVU/REM/REMU bundle hands off (OUT_VALID&&OUT_READY); counter loads DIV_CYCLES-1, decrements each cycle; WAIT_DIV->RUN when counter==0.
REQ-013 BUSY SHALL be 1 exactly in WAIT_DIV; IN_READY=0 throughout, giving exactly DIV_CYCLES cycles of IN_READY low attributable to the reservation.
REQ-014 FLUSH SHALL, next edge, clear OUT_VALID, force state RUN, clear counter; an instruction presented with FLUSH is not accepted; FLUSH beats a simultaneous handoff (no WAIT_DIV entry).
REQ-015 MUL/MULH/MULHSU/MULHU SHALL NOT trigger WAIT_DIV.

Reset
REQ-016 RESET SHALL, at the next CLK edge, set OUT_VALID=0, state RUN, counter 0, BUSY 0, ILLEGAL 0, ALUOP 00000, MUXIMMTYPE_SELECT 111, all other control outputs and FUNCT3_OUT 0.
REQ-017 RESET mid-WAIT_DIV or with a held bundle SHALL abandon both; IN_READY=1 the cycle after RESET deasserts.

Verification
REQ-018 Back-to-back add x3,x1,x2 (0x002081B3) then lw, OUT_READY=1 -> outputs ALUOP 00001 WE=1, then MUXDATAMEM=1 MR=1, one bundle per cycle, no bubble.
REQ-019 sub with OUT_READY=0 for 3 cycles -> OUT_VALID held, ALUOP 00010 stable, IN_READY=0, then single handoff.
REQ-020 div (0x0220C1B3), DIV_CYCLES=4, handed off -> BUSY=1, IN_READY=0 for exactly 4 cycles, then RUN.
REQ-021 ENABLE_M=0, mul (0x022081B3) -> ILLEGAL=1, WE=0, ALUOP 00000, no WAIT_DIV; opcode 0x7F -> ILLEGAL=1.
REQ-022 FLUSH asserted during div handoff -> OUT_VALID=0 next cycle, BUSY stays 0.
REQ-023 RESET asserted at WAIT_DIV counter 2 -> all REQ-016 values next cycle, IN_READY=1 after release.
